// File: rtl/onehot_seq_encoder.sv
// onehot_seq_encoder: emits the binary index of every set request bit, lowest first,
// one index per out handshake; one request vector is held at a time.
module onehot_seq_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_last,
    output logic [W:0]   out_cnt,
    output logic         zero_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] pending;
    logic [W-1:0] idx;
    logic [W:0]   cnt;

    // Downward scan so the lowest set bit wins the index.
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = W'(i);
            cnt = cnt + (W + 1)'(pending[i]);
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);
    assign out       = out_valid ? idx : '0;
    assign out_cnt   = out_valid ? cnt : '0;
    assign out_last  = out_valid && (cnt == (W + 1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            zero_err <= 1'b0;
        end else begin
            zero_err <= in_ready && in_valid && (in == '0);
            if (in_ready && in_valid && (in != '0)) begin
                pending <= in;
                state   <= EMIT;
            end else if (out_valid && out_ready) begin
                // x & (x-1) drops the lowest set bit, i.e. the one just emitted.
                pending <= pending & (pending - N'(1));
                if (out_last) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_onehot_seq_encoder.sv
// tb_onehot_seq_encoder: scoreboard bench; expected {out,out_last,out_cnt} tuples are
// queued when a vector is driven and popped on each observed transfer.
module tb_onehot_seq_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out;
    logic       out_last;
    logic [3:0] out_cnt;
    logic       zero_err;

    logic [7:0] q[$];
    logic [7:0] e;
    int vectors = 0;
    int errors = 0;

    onehot_seq_encoder #(.N(8), .W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_last(out_last),
        .out_cnt(out_cnt), .zero_err(zero_err)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] v);
        int rem = 0;
        for (int i = 0; i < 8; i++) rem += int'(v[i]);
        for (int i = 0; i < 8; i++)
            if (v[i]) begin
                q.push_back({3'(i), rem == 1, 4'(rem)});
                rem--;
            end
    endtask

    task automatic send(input logic [7:0] v);
        int c = 0;
        @(negedge clk);
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        in = v;
        push_exp(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({in_ready, out_valid, out, zero_err} !== 6'b0) begin
                errors++;
                $display("FAIL reset_state: rdy=%b vld=%b out=%0d zerr=%b want all 0",
                         in_ready, out_valid, out, zero_err);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single;
        send(8'b0010_0000);
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency: out_valid=%b want 1", out_valid);
                end
            end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                vectors++;
                if ({out, out_last, out_cnt} !== e) begin
                    errors++;
                    $display("FAIL single_xfer: got %h want %h", {out, out_last, out_cnt}, e);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (q.size() != 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: left=%0d rdy=%b vld=%b want 0 1 0", q.size(), in_ready, out_valid);
            q.delete();
        end
    endtask

    task automatic test_multi;
        send(8'b1001_0010);
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL multi_gap: out_valid=%b want 1 (back-to-back)", out_valid);
            end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                vectors++;
                if ({out, out_last, out_cnt} !== e) begin
                    errors++;
                    $display("FAIL multi_xfer: got %h want %h", {out, out_last, out_cnt}, e);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (q.size() != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL multi_done: left=%0d rdy=%b want 0 1", q.size(), in_ready);
            q.delete();
        end
    endtask

    task automatic test_backpressure;
        send(8'b0001_0100);
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || {out, out_last, out_cnt} !== e) begin
            errors++;
            $display("FAIL bp_first: vld=%b got %h want %h", out_valid, {out, out_last, out_cnt}, e);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, out, out_last, out_cnt} !== {1'b1, 3'd4, 1'b1, 4'd1}) begin
                errors++;
                $display("FAIL bp_hold: vld=%b out=%0d last=%b cnt=%0d want 1 4 1 1",
                         out_valid, out, out_last, out_cnt);
            end
        end
        e = q.pop_front();
        vectors++;
        if ({out, out_last, out_cnt} !== e) begin
            errors++;
            $display("FAIL bp_second: got %h want %h", {out, out_last, out_cnt}, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero_full;
        send(8'h00);
        @(negedge clk);
        vectors++;
        if (zero_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: zerr=%b vld=%b rdy=%b want 1 0 1", zero_err, out_valid, in_ready);
        end
        in_valid = 1'b1;
        in = 8'hFF;
        push_exp(8'hFF);
        @(posedge clk);
        #1 in = 8'h01;
        for (int c = 0; c < 30 && q.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if (zero_err !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_width: zero_err=%b want 0", zero_err);
                end
            end
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_emit: vld=%b rdy=%b want 1 0", out_valid, in_ready);
            end
            if (out_valid && out_ready) begin
                e = q.pop_front();
                vectors++;
                if ({out, out_last, out_cnt} !== e) begin
                    errors++;
                    $display("FAIL full_xfer: got %h want %h", {out, out_last, out_cnt}, e);
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_done: left=%0d vld=%b rdy=%b want 0 0 1", q.size(), out_valid, in_ready);
            q.delete();
        end
    endtask

    task automatic test_reset_mid;
        send(8'b1111_0000);
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({out, out_last, out_cnt} !== e) begin
            errors++;
            $display("FAIL mid_first: got %h want %h", {out, out_last, out_cnt}, e);
        end
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        vectors++;
        if ({out_valid, out, in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: vld=%b out=%0d rdy=%b want 0 0 0", out_valid, out, in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || out !== 3'd0) begin
                errors++;
                $display("FAIL mid_leftover: vld=%b out=%0d want 0 0", out_valid, out);
            end
        end
        send(8'b0000_0001);
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = q.pop_front();
                vectors++;
                if ({out, out_last, out_cnt} !== e) begin
                    errors++;
                    $display("FAIL mid_after: got %h want %h", {out, out_last, out_cnt}, e);
                end
            end
        end
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL mid_timeout: %0d indices missing want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_backpressure;
        test_zero_full;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/onehot_seq_encoder.md
Name: onehot_seq_encoder

Overview:
- Inverse companion to the 3-to-8 one-hot decoder: accepts an 8-bit request vector and emits the 3-bit binary index of every set bit, one index per transfer, lowest index first.
- Sits between a bank of 8 request lines and any downstream consumer of 3-bit select codes.
- Valid/ready handshakes on both sides; one vector is processed at a time.

Parameters:
- N, 8, number of input lines; must equal 2**W.
- W, 3, index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector.
- in  input  N  request vector; any number of bits may be set.
- out_valid  output  1  index on `out` is valid.
- out_ready  input  1  consumer accepts the index.
- out  output  W  binary index of the lowest pending set bit.
- out_last  output  1  current index is the final one for this vector.
- out_cnt  output  W+1  indices remaining, including the current one.
- zero_err  output  1  one-cycle pulse when an all-zero vector is accepted.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; the pending register clears to 0.
  - Outputs: out_valid=0, out=0, out_last=0, out_cnt=0, zero_err=0.
  - in_ready=0 while rst is high.
  - A reset mid-emission abandons the remaining indices. No partial output appears after rst deasserts.
- State IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid=1 and in!=0 at an edge: latch pending=in and go to EMIT.
  - When in_valid=1 and in==0 at an edge: the vector is consumed, state stays IDLE, zero_err=1 for exactly the next cycle.
- State EMIT:
  - in_ready=0 and out_valid=1.
  - out = index of the lowest set bit of pending.
  - out_cnt = popcount(pending).
  - out_last=1 iff popcount(pending)==1.
  - Outputs are decoded from registers only; no combinational path from `in` or in_valid to any output.
- Transfer: an edge with out_valid=1 and out_ready=1.
  - The transfer clears the emitted bit in pending.
  - If out_last=1, state returns to IDLE.
  - Otherwise the next index is presented the following cycle, so back-to-back transfers run one per clock.
- Backpressure: while out_ready=0, out, out_last and out_cnt hold stable and out_valid stays high.
- Latency:
  - Vector accepted at edge k: first out_valid is seen in the cycle after edge k.
  - Last transfer at edge m: in_ready=1 in the cycle after edge m.
  - A vector with p set bits needs at least p+1 cycles from acceptance until the next acceptance.
- Simultaneous events:
  - in_valid is ignored while in_ready=0 (the block drops no data because it does not accept).
  - rst has priority over every handshake.
- Width rules: out_cnt is W+1 bits so it can represent 8 for in=8'hFF. out=0 whenever out_valid=0.
- Errors: zero_err does not block acceptance of a new vector on the following cycle.

Test Plan:
- Hold rst=1 for 2 cycles, then release. Require:
  - During reset: in_ready=0, out_valid=0, out=0, zero_err=0.
  - First cycle after release: in_ready=1.
- Single bit: in=8'b0010_0000, out_ready=1. Require one transfer with out=5, out_last=1, out_cnt=1, then in_ready=1 the next cycle.
- Multi-bit: in=8'b1001_0010, out_ready=1. Require:
  - Consecutive transfers out=1,4,7 with out_cnt=3,2,1.
  - out_last=1 only with out=7.
- Backpressure: in=8'b0001_0100. Drop out_ready for 3 cycles after the first transfer. Require out=4, out_cnt=1, out_last=1 to stay stable with out_valid=1 until out_ready returns.
- Zero vector and full vector:
  - in=8'h00 accepted: zero_err pulses for 1 cycle, out_valid stays 0.
  - Then in=8'hFF: out=0..7 on 8 consecutive cycles, out_cnt=8 down to 1.
  - in_valid held high during EMIT is not accepted.
- Reset mid-emission: in=8'b1111_0000. Assert rst after the out=4 transfer. Require out_valid=0, with no out=5..7 afterwards, and a new in=8'b0000_0001 yields out=0.
